// File: rtl/imm_extend_stage.sv
// Immediate-extension stage: field select, sign/zero extend, shift, tag carry.
// Two-entry (output + skid) register pair behind a valid/ready handshake.
module imm_extend_stage #(
    parameter int DATA_W = 32,
    parameter int IN_W   = 28,
    parameter int W0     = 15,
    parameter int W1     = 19,
    parameter int W2     = 23,
    parameter int W3     = 28,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_imm,
    input  logic [1:0]        in_sel,
    input  logic              in_zext,
    input  logic [1:0]        in_shamt,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_imm,
    output logic [TAG_W-1:0]  out_tag
);

    localparam int WS [4] = '{W0, W1, W2, W3};

    if (W0 > IN_W || W1 > IN_W || W2 > IN_W || W3 > IN_W ||
        W0 + 3 > DATA_W || W1 + 3 > DATA_W || W2 + 3 > DATA_W || W3 + 3 > DATA_W) begin : g_illegal
        $error("imm_extend_stage: illegal field widths");
    end

    // One extender per field width; the select only picks among finished results.
    logic [3:0][DATA_W-1:0] ext_all;
    for (genvar g = 0; g < 4; g++) begin : g_fld
        localparam int W = WS[g];
        logic fill;
        assign fill       = ~in_zext & in_imm[W-1];
        assign ext_all[g] = {{(DATA_W-W){fill}}, in_imm[W-1:0]};
    end

    logic [DATA_W-1:0] res;
    assign res = ext_all[in_sel] << in_shamt;

    logic              or_vld_q, or_vld_d;
    logic [DATA_W-1:0] or_imm_q, or_imm_d;
    logic [TAG_W-1:0]  or_tag_q, or_tag_d;
    logic              sk_vld_q, sk_vld_d;
    logic [DATA_W-1:0] sk_imm_q, sk_imm_d;
    logic [TAG_W-1:0]  sk_tag_q, sk_tag_d;

    logic acc, drain;

    assign in_ready  = ~sk_vld_q & ~rst;
    assign out_valid = or_vld_q;
    assign out_imm   = or_imm_q;
    assign out_tag   = or_tag_q;

    assign acc   = in_valid & in_ready & ~flush;
    assign drain = or_vld_q & out_ready;

    always_comb begin
        or_vld_d = or_vld_q;
        or_imm_d = or_imm_q;
        or_tag_d = or_tag_q;
        sk_vld_d = sk_vld_q;
        sk_imm_d = sk_imm_q;
        sk_tag_d = sk_tag_q;
        if (flush) begin
            or_vld_d = 1'b0;
            sk_vld_d = 1'b0;
        end else if (!or_vld_q || drain) begin
            // SK full implies in_ready=0, so no accept competes with the SK->OR move
            if (sk_vld_q) begin
                or_vld_d = 1'b1;
                or_imm_d = sk_imm_q;
                or_tag_d = sk_tag_q;
                sk_vld_d = 1'b0;
            end else if (acc) begin
                or_vld_d = 1'b1;
                or_imm_d = res;
                or_tag_d = in_tag;
            end else begin
                or_vld_d = 1'b0;
            end
        end else if (acc) begin
            sk_vld_d = 1'b1;
            sk_imm_d = res;
            sk_tag_d = in_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            or_vld_q <= 1'b0;
            or_imm_q <= '0;
            or_tag_q <= '0;
            sk_vld_q <= 1'b0;
            sk_imm_q <= '0;
            sk_tag_q <= '0;
        end else begin
            or_vld_q <= or_vld_d;
            or_imm_q <= or_imm_d;
            or_tag_q <= or_tag_d;
            sk_vld_q <= sk_vld_d;
            sk_imm_q <= sk_imm_d;
            sk_tag_q <= sk_tag_d;
        end
    end

endmodule

// File: tb/tb_imm_extend_stage.sv
// Bench for imm_extend_stage: directed cases plus random streaming against
// an arithmetic reference model and a FIFO scoreboard.
module tb_imm_extend_stage;

    localparam int DATA_W = 32;
    localparam int IN_W   = 28;
    localparam int TAG_W  = 5;
    localparam int WID [4] = '{15, 19, 23, 28};

    logic              clk = 1'b0;
    logic              rst, flush, in_valid, in_ready, in_zext, out_valid, out_ready;
    logic [IN_W-1:0]   in_imm;
    logic [1:0]        in_sel, in_shamt;
    logic [TAG_W-1:0]  in_tag, out_tag;
    logic [DATA_W-1:0] out_imm;

    int nchk = 0;
    int nerr = 0;
    bit last_in_fire;
    logic [DATA_W+TAG_W-1:0] sb [$];

    always #5 clk = ~clk;

    imm_extend_stage #(.DATA_W(DATA_W), .IN_W(IN_W), .W0(15), .W1(19), .W2(23), .W3(28), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_sel(in_sel),
        .in_zext(in_zext), .in_shamt(in_shamt), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm), .out_tag(out_tag)
    );

    function automatic logic [DATA_W-1:0] ref_imm(logic [IN_W-1:0] imm, int sel, bit zext, int sh);
        int     w = WID[sel];
        longint f = longint'(imm) % (longint'(1) << w);
        longint r;
        if (!zext && f >= (longint'(1) << (w - 1))) f = f - (longint'(1) << w);
        r = f * (longint'(1) << sh);
        return r[DATA_W-1:0];
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic drive(input bit v, input logic [IN_W-1:0] imm, input int sel, input bit z,
                         input int sh, input int tag);
        in_valid = v;
        in_imm   = imm;
        in_sel   = 2'(sel);
        in_zext  = z;
        in_shamt = 2'(sh);
        in_tag   = TAG_W'(tag);
    endtask

    // One clock: check occupancy-derived flags, score any output transfer,
    // record any input transfer, then advance past the edge.
    task automatic tick();
        bit inf, outf;
        logic [DATA_W+TAG_W-1:0] e;
        chk("out_valid_vs_model", 64'(out_valid), 64'(sb.size() != 0));
        chk("in_ready_vs_model", 64'(in_ready), 64'(!rst && sb.size() < 2));
        inf  = in_valid && in_ready && !flush && !rst;
        outf = out_valid && out_ready;
        if (outf) begin
            if (sb.size() == 0) chk("unexpected_output", 64'(out_tag), 64'hDEAD);
            else begin
                e = sb.pop_front();
                chk("out_imm", 64'(out_imm), 64'(e[DATA_W+TAG_W-1:TAG_W]));
                chk("out_tag", 64'(out_tag), 64'(e[TAG_W-1:0]));
            end
        end
        if (rst || flush) sb.delete();
        if (inf) sb.push_back({ref_imm(in_imm, int'(in_sel), in_zext, int'(in_shamt)), in_tag});
        last_in_fire = inf;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(0, '0, 0, 0, 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_imm", 64'(out_imm), 64'd0);
        chk("reset_out_tag", 64'(out_tag), 64'd0);
        chk("reset_in_ready_low", 64'(in_ready), 64'd0);
        rst = 1'b0;
        #1;
        chk("in_ready_after_reset", 64'(in_ready), 64'd1);

        // directed extension cases
        out_ready = 1'b1;
        drive(1, 28'h0004000, 0, 0, 0, 1); tick(); drive(0, '0, 0, 0, 0, 0);
        chk("sext15", 64'(out_imm), 64'hFFFFC000);
        drive(1, 28'h0004000, 0, 1, 0, 2); tick(); drive(0, '0, 0, 0, 0, 0);
        chk("zext15", 64'(out_imm), 64'h00004000);
        drive(1, 28'hFF7FFFF, 1, 0, 2, 3); tick(); drive(0, '0, 0, 0, 0, 0);
        chk("sel1_upper_ignored_sh2", 64'(out_imm), 64'hFFFFFFFC);
        drive(1, 28'h8000000, 3, 0, 3, 4); tick(); drive(0, '0, 0, 0, 0, 0);
        chk("sel3_sh3", 64'(out_imm), 64'hC0000000);
        tick();

        // backpressure: 1 -> OR, 2 -> SK, 3 must wait
        out_ready = 1'b0;
        drive(1, 28'h0000011, 0, 1, 0, 1); tick();
        chk("bp_accept1", 64'(last_in_fire), 64'd1);
        drive(1, 28'h0000022, 0, 1, 0, 2); tick();
        chk("bp_accept2", 64'(last_in_fire), 64'd1);
        drive(1, 28'h0000033, 0, 1, 0, 3);
        chk("bp_full_in_ready", 64'(in_ready), 64'd0);
        tick(); tick();
        chk("bp_tag3_held", 64'(last_in_fire), 64'd0);
        out_ready = 1'b1;
        chk("bp_first_out", 64'(out_tag), 64'd1);
        tick();
        chk("bp_second_out", 64'(out_tag), 64'd2);
        for (int i = 0; i < 4 && !last_in_fire; i++) tick();
        drive(0, '0, 0, 0, 0, 0);
        chk("bp_tag3_accepted", 64'(last_in_fire), 64'd1);
        chk("bp_third_out", 64'(out_tag), 64'd3);
        chk("bp_third_valid", 64'(out_valid), 64'd1);
        tick();

        // random streaming, one output per cycle, latency one
        for (int i = 0; i < 16; i++) begin
            drive(1, 28'($urandom), int'($urandom_range(0, 3)), 1'($urandom),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 31)));
            tick();
            chk("stream_latency", 64'(sb.size()), 64'd1);
        end
        drive(0, '0, 0, 0, 0, 0);
        tick(); tick();

        // flush with both entries full and tag 7 presented
        out_ready = 1'b0;
        drive(1, 28'h0000101, 2, 0, 1, 10); tick();
        drive(1, 28'h0000202, 2, 0, 1, 11); tick();
        drive(1, 28'h0000303, 2, 0, 1, 7);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(0, '0, 0, 0, 0, 0);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        tick(); tick();
        chk("flush_no_tag7", 64'(out_valid), 64'd0);

        // reset while both entries full and stalled
        out_ready = 1'b0;
        drive(1, 28'h1234567, 3, 0, 0, 20); tick();
        drive(1, 28'h7654321, 3, 0, 0, 21); tick();
        drive(0, '0, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        chk("rst_in_ready_low", 64'(in_ready), 64'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_imm", 64'(out_imm), 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        chk("rst_in_ready_after", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        tick(); tick();
        chk("rst_no_stale", 64'(out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/imm_extend_stage.md
Name: imm_extend_stage

Overview:
- Pipelined, parametrised immediate-extension stage between the instruction decoder and the execute-operand mux.
- Function per accepted immediate:
  - selects one of four field widths;
  - sign- or zero-extends it to DATA_W;
  - optionally left-shifts it by 0-3 (byte/half/word/dword offsets);
  - carries a tag (e.g. destination register) alongside.
- Decoupled from decode and execute by a valid/ready handshake with a 2-entry skid buffer, so full throughput is kept under backpressure.

Parameters:
- DATA_W, 32: output width.
- IN_W, 28: raw immediate input width.
- W0, 15: field width for sel=0.
- W1, 19: field width for sel=1.
- W2, 23: field width for sel=2.
- W3, 28: field width for sel=3.
- TAG_W, 5: sideband tag width.
- Legal only if every Wi <= IN_W and Wi + 3 <= DATA_W (elaboration-time assertion).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all buffered entries (pipeline redirect).
- in_valid  in  1  input transaction present.
- in_ready  out  1  stage can accept an input.
- in_imm  in  IN_W  raw immediate; bits above the selected width are ignored.
- in_sel  in  2  field-width select (0..3 -> W0..W3).
- in_zext  in  1  1 = zero-extend, 0 = sign-extend from bit Wsel-1.
- in_shamt  in  2  left-shift amount applied after extension.
- in_tag  in  TAG_W  sideband, passed through unchanged.
- out_valid  out  1  output transaction present.
- out_ready  in  1  consumer accepts output.
- out_imm  out  DATA_W  extended and shifted immediate.
- out_tag  out  TAG_W  tag of out_imm.

Behaviour:
- Reset (rst=1 at a clock edge):
  - Clears out_valid, the skid valid, out_imm = 0 and out_tag = 0.
  - in_ready is 0 while rst is high and 1 in the first cycle after.
  - Reset mid-transfer drops all in-flight entries; nothing is replayed.
- Handshake:
  - Input transfer occurs on in_valid & in_ready.
  - Output transfer occurs on out_valid & out_ready.
  - Payload must be held stable by the producer while valid and not ready; the stage holds out_* stable while out_valid & !out_ready.
- Datapath (combinational, before the register):
  - f = in_imm[Wsel-1:0].
  - ext = zext ? zero-pad(f) : replicate(f[Wsel-1]) ++ f, to DATA_W.
  - result = (ext << in_shamt) truncated to DATA_W.
  - No bit of in_imm at or above Wsel affects the result.
- Latency: one cycle; an accepted input appears on out_* the next cycle when the output register is empty or draining.
- Storage: two entries, output register (OR) and skid register (SK).
  - in_ready = !SK.valid, registered; it does not depend combinationally on out_ready.
  - Accept with OR empty or draining this cycle: the new entry goes to OR.
  - Accept with OR full and stalled: the new entry goes to SK.
  - OR draining and SK full: SK moves to OR and SK empties.
  - Order is strictly FIFO; no entry is ever dropped or duplicated.
  - Throughput: one per cycle whenever out_ready stays high.
- Full/empty boundaries:
  - Both entries full: in_ready = 0; an input held on in_valid waits.
  - Both empty: out_valid = 0; out_imm/out_tag hold their last value (don't-care to consumers).
- flush:
  - Next cycle out_valid = 0, SK empty, in_ready = 1.
  - An input presented in the flush cycle is discarded even if in_ready = 1.
  - A simultaneous output transfer in the flush cycle is still counted as delivered.
- rst has priority over flush; flush has priority over accept.

Test Plan:
- Sign-extend 15-bit field: sel=0, in_imm=0x0004000, zext=0, shamt=0 -> out_imm=0xFFFFC000 one cycle later; same with zext=1 -> 0x00004000.
- Ignored upper bits and shift: sel=1, in_imm=0xFF7FFFF, zext=0, shamt=2 -> field 0x7FFFF sign-extends to 0xFFFFFFFF, out_imm=0xFFFFFFFC; sel=3, in_imm=0x8000000, shamt=3 -> 0xC0000000.
- Backpressure order:
  - Stimulus: out_ready=0, push tags 1,2,3 back-to-back.
  - Required while stalled: tags 1 and 2 accepted; in_ready=0 on cycle 3 with tag 3 held.
  - Required after out_ready=1: outputs 1,2,3 in order on consecutive cycles, no gaps.
- Streaming: 16 random inputs with out_ready=1 -> 16 outputs, each exactly one cycle after its input, matching the reference model bit-exact.
- Flush: OR and SK full, assert flush with in_valid=1 (tag 7) -> next cycle out_valid=0, in_ready=1, tag 7 never emitted.
- Mid-transfer reset: rst=1 while both entries are full and out_ready=0 -> next cycle out_valid=0, out_imm=0, out_tag=0; in_ready=0 during reset, 1 after; no stale entry emitted afterwards.
